// File: rtl/dot_operand_loader_pkg.sv
// Shared constants and state encoding for the dot-product operand loader.
package dot_pkg;

  localparam int unsigned N  = 10;
  localparam int unsigned W  = 4;
  localparam int unsigned CW = 8;

  typedef logic [0:0] state_t;

  localparam state_t LOAD = 1'b0;
  localparam state_t FULL = 1'b1;

endpackage

// File: rtl/dot_operand_loader_operand_bank.sv
// N-entry register file of (x,y) operand pairs with indexed write and packed read-out.
module operand_bank #(
  parameter int unsigned N  = 10,
  parameter int unsigned W  = 4,
  parameter int unsigned IW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [IW-1:0]   widx,
  input  logic [W-1:0]    wx,
  input  logic [W-1:0]    wy,
  output logic [N*W-1:0]  x_vec,
  output logic [N*W-1:0]  y_vec
);

  logic [W-1:0] xr [N];
  logic [W-1:0] yr [N];

  // Decoded write keeps out-of-range indices from touching any entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        xr[i] <= '0;
        yr[i] <= '0;
      end
    end else if (we) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (IW'(i) == widx) begin
          xr[i] <= wx;
          yr[i] <= wy;
        end
      end
    end
  end

  always_comb begin
    x_vec = '0;
    y_vec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      x_vec[i*W +: W] = xr[i];
      y_vec[i*W +: W] = yr[i];
    end
  end

endmodule

// File: rtl/dot_operand_loader.sv
// Collects N streamed (x,y) pairs into a parallel vector and holds it until downstream accepts.
module dot_operand_loader #(
  parameter int unsigned N  = dot_pkg::N,
  parameter int unsigned W  = dot_pkg::W,
  parameter int unsigned CW = dot_pkg::CW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         x_in,
  input  logic [W-1:0]         y_in,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  output logic [N*W-1:0]       x_vec,
  output logic [N*W-1:0]       y_vec,
  output logic [$clog2(N)-1:0] fill_cnt,
  output logic [CW-1:0]        vec_cnt
);

  import dot_pkg::*;

  localparam int unsigned IW = $clog2(N);

  state_t state;
  logic   accept;
  logic   handoff;
  logic   last;

  always_comb begin
    in_ready  = (state == LOAD) & ~flush;
    vec_valid = (state == FULL);
    accept    = in_valid & in_ready;
    handoff   = vec_valid & vec_ready & ~flush;
    last      = (fill_cnt == IW'(N - 1));
  end

  // flush outranks both the accept and the handoff paths
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      fill_cnt <= '0;
      vec_cnt  <= '0;
    end else if (flush) begin
      state    <= LOAD;
      fill_cnt <= '0;
    end else if (accept) begin
      if (last) begin
        fill_cnt <= '0;
        state    <= FULL;
      end else begin
        fill_cnt <= fill_cnt + 1'b1;
      end
    end else if (handoff) begin
      state   <= LOAD;
      vec_cnt <= vec_cnt + 1'b1;
    end
  end

  operand_bank #(
    .N  (N),
    .W  (W),
    .IW (IW)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .widx  (fill_cnt),
    .wx    (x_in),
    .wy    (y_in),
    .x_vec (x_vec),
    .y_vec (y_vec)
  );

endmodule

// File: tb/tb_dot_operand_loader.sv
// Scoreboard bench for dot_operand_loader: a pair-list reference model predicts vectors and handshakes.
module tb_dot_operand_loader;

  localparam int N  = 10;
  localparam int W  = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          vec_ready = 1'b0;
  logic [W-1:0]  x_in = '0;
  logic [W-1:0]  y_in = '0;
  logic          in_ready;
  logic          vec_valid;
  logic [N*W-1:0] x_vec;
  logic [N*W-1:0] y_vec;
  logic [3:0]    fill_cnt;
  logic [CW-1:0] vec_cnt;

  always #5 clk = ~clk;

  dot_operand_loader #(.N(N), .W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .y_in      (y_in),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .x_vec     (x_vec),
    .y_vec     (y_vec),
    .fill_cnt  (fill_cnt),
    .vec_cnt   (vec_cnt)
  );

  typedef struct { logic [3:0] x; logic [3:0] y; } pair_t;
  typedef struct { logic [N*W-1:0] x; logic [N*W-1:0] y; int p; } vec_t;

  pair_t m_pairs[$];
  vec_t  exp_q[$];
  bit    m_hold = 0;
  int    m_vcnt = 0;
  bit    m_took = 1;
  bit    mon_en = 0;
  int    checks = 0;
  int    failures = 0;
  int    handoffs = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int dotp(logic [N*W-1:0] x, logic [N*W-1:0] y);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(x[i*W +: W]) * int'(y[i*W +: W]);
    return s;
  endfunction

  // Reference model: a list of accepted pairs; N of them become one expected vector.
  always @(posedge clk) begin
    m_took = 0;
    if (rst_n) begin
      if (flush) begin
        m_hold = 0;
        m_pairs.delete();
        exp_q.delete();
      end else if (m_hold) begin
        if (vec_ready) begin
          m_hold = 0;
          m_vcnt = (m_vcnt + 1) % 256;
        end
      end else if (in_valid) begin
        pair_t pr;
        pr.x = x_in;
        pr.y = y_in;
        m_pairs.push_back(pr);
        m_took = 1;
        if (m_pairs.size() == N) begin
          vec_t v;
          v.x = '0;
          v.y = '0;
          v.p = 0;
          foreach (m_pairs[i]) begin
            v.x[i*W +: W] = m_pairs[i].x;
            v.y[i*W +: W] = m_pairs[i].y;
            v.p += int'(m_pairs[i].x) * int'(m_pairs[i].y);
          end
          exp_q.push_back(v);
          m_pairs.delete();
          m_hold = 1;
        end
      end
    end
  end

  // Monitor: compares handshakes every cycle and the held vector against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("in_ready", 64'(in_ready), 64'(!m_hold && !flush));
      check("vec_valid", 64'(vec_valid), 64'(m_hold));
      check("fill_cnt", 64'(fill_cnt), 64'(m_pairs.size()));
      check("vec_cnt", 64'(vec_cnt), 64'(m_vcnt));
      if (m_hold) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty got=vec_valid exp=no_vector t=%0t", $time);
        end else begin
          check("x_vec", 64'(x_vec), 64'(exp_q[0].x));
          check("y_vec", 64'(y_vec), 64'(exp_q[0].y));
          check("dot_p", 64'(dotp(x_vec, y_vec)), 64'(exp_q[0].p));
          if (vec_ready && !flush) begin
            void'(exp_q.pop_front());
            handoffs++;
          end
        end
      end
    end
  end

  // mode 0: x=i,y=i+1; mode 1: x=y=c; otherwise random, held until accepted
  task automatic drive(bit v, bit vr, bit fl, int mode, logic [3:0] c);
    @(posedge clk);
    #1;
    in_valid  = v;
    vec_ready = vr;
    flush     = fl;
    case (mode)
      0: begin
        x_in = 4'(m_pairs.size());
        y_in = 4'(m_pairs.size() + 1);
      end
      1: begin
        x_in = c;
        y_in = c;
      end
      default: begin
        if (m_took) begin
          x_in = 4'($urandom);
          y_in = 4'($urandom);
        end
      end
    endcase
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tag, "_vec_valid"}, 64'(vec_valid), 64'(0));
    check({tag, "_fill_cnt"}, 64'(fill_cnt), 64'(0));
    check({tag, "_vec_cnt"}, 64'(vec_cnt), 64'(0));
    check({tag, "_x_vec"}, 64'(x_vec), 64'(0));
    check({tag, "_y_vec"}, 64'(y_vec), 64'(0));
  endtask

  initial begin
    int start_h;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 mon_en = 1;

    // 1: back-to-back index pattern, P=330
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    check("t1_vec_cnt", 64'(vec_cnt), 64'(1));

    // 2: hold with vec_ready low while upstream keeps offering
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 1, 4'd7);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 1, 4'd9);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 1, 4'd9);

    // 3: alternating in_valid, all 15s, P=2250
    drive(0, 1, 1, 1, 4'd15);
    for (int i = 0; i < 24; i++) drive(i % 2 == 0, 1, 0, 1, 4'd15);

    // 4: flush after 6 pairs, then all 2s
    drive(0, 1, 1, 2, 0);
    for (int i = 0; i < 6; i++) drive(1, 1, 0, 2, 0);
    drive(1, 1, 1, 2, 0);
    for (int i = 0; i < 12; i++) drive(1, 1, 0, 1, 4'd2);

    // 5: flush together with vec_valid & vec_ready
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 12; i++) drive(1, 0, 0, 1, 4'd5);
    drive(1, 1, 1, 1, 4'd5);
    drive(0, 1, 0, 1, 4'd5);

    // randomized traffic
    for (int i = 0; i < 800; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 60) == 0, 2, 0);

    // 6a: 256 handoffs wrap vec_cnt
    drive(0, 1, 1, 2, 0);
    start_h = handoffs;
    for (int k = 0; k < 4000 && handoffs - start_h < 256; k++) drive(1, 1, 0, 2, 0);
    check("wrap_handoffs", 64'(handoffs - start_h), 64'(256));

    // 6b: async reset mid-fill
    drive(0, 1, 1, 1, 4'd3);
    for (int k = 0; k < 30 && m_pairs.size() != 4; k++) drive(1, 1, 0, 1, 4'd3);
    check("pre_reset_fill", 64'(fill_cnt), 64'(4));
    @(negedge clk);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("async");
    m_pairs.delete();
    exp_q.delete();
    m_hold = 0;
    m_vcnt = 0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0);
    check("post_reset_vec_cnt", 64'(vec_cnt), 64'(1));
    check("min_handoffs", 64'(handoffs >= 260), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
